// File: rtl/lcd_pkg.sv
// Shared constants, FSM state encoding and init/window ROM entry format
// for the ILI9341 8080-parallel write controller.
package lcd_pkg;

    // ILI9341 command opcodes
    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] CMD_MADCTL = 8'h36;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    // Pixel format for COLMOD: 16 bpp RGB565
    localparam logic [7:0] COLMOD_16BPP = 8'h55;

    // Shared delay counter width (holds 1920000)
    localparam int DLY_W = 21;

    // ROM layout: init bytes 0..5, window bytes 6..16
    localparam int ROM_IDX_W = 5;
    localparam logic [ROM_IDX_W-1:0] ROM_INIT_LAST = 5'd5;
    localparam logic [ROM_IDX_W-1:0] ROM_WIN_START = 5'd6;
    localparam logic [ROM_IDX_W-1:0] ROM_WIN_LAST  = 5'd16;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_INIT_DLY,
        ST_WIN,
        ST_IDLE,
        ST_PIX
    } lcd_state_t;

    // dly: wait RST_WAIT_CYCLES after this byte; dc: 0 = command, 1 = data
    typedef struct packed {
        logic       dly;
        logic       dc;
        logic [7:0] data;
    } rom_entry_t;

    function automatic rom_entry_t mk_entry(input logic dly, input logic dc,
                                            input logic [7:0] data);
        rom_entry_t e;
        e.dly  = dly;
        e.dc   = dc;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational index-to-entry table for the panel bring-up sequence and
// the full-screen address window that is re-sent on every cursor reset.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter logic [7:0] MADCTL   = 8'h48,
    parameter int unsigned COL_END  = 239,
    parameter int unsigned PAGE_END = 319
) (
    input  logic [ROM_IDX_W-1:0] i_idx,
    output rom_entry_t           o_entry
);

    localparam logic [15:0] COL_W  = 16'(COL_END);
    localparam logic [15:0] PAGE_W = 16'(PAGE_END);

    // Sequence table; indices past the window end read as all-zero
    always_comb begin
        o_entry = '0;
        case (i_idx)
            5'd0:  o_entry = mk_entry(1'b1, 1'b0, CMD_SLPOUT);
            5'd1:  o_entry = mk_entry(1'b0, 1'b0, CMD_COLMOD);
            5'd2:  o_entry = mk_entry(1'b0, 1'b1, COLMOD_16BPP);
            5'd3:  o_entry = mk_entry(1'b0, 1'b0, CMD_MADCTL);
            5'd4:  o_entry = mk_entry(1'b0, 1'b1, MADCTL);
            5'd5:  o_entry = mk_entry(1'b0, 1'b0, CMD_DISPON);
            5'd6:  o_entry = mk_entry(1'b0, 1'b0, CMD_CASET);
            5'd7:  o_entry = mk_entry(1'b0, 1'b1, 8'h00);
            5'd8:  o_entry = mk_entry(1'b0, 1'b1, 8'h00);
            5'd9:  o_entry = mk_entry(1'b0, 1'b1, COL_W[15:8]);
            5'd10: o_entry = mk_entry(1'b0, 1'b1, COL_W[7:0]);
            5'd11: o_entry = mk_entry(1'b0, 1'b0, CMD_PASET);
            5'd12: o_entry = mk_entry(1'b0, 1'b1, 8'h00);
            5'd13: o_entry = mk_entry(1'b0, 1'b1, 8'h00);
            5'd14: o_entry = mk_entry(1'b0, 1'b1, PAGE_W[15:8]);
            5'd15: o_entry = mk_entry(1'b0, 1'b1, PAGE_W[7:0]);
            5'd16: o_entry = mk_entry(1'b0, 1'b0, CMD_RAMWR);
            default: o_entry = '0;
        endcase
    end

endmodule

// File: rtl/lcd_8080_ctrl.sv
// ILI9341 8-bit 8080 write controller: panel reset, init, window setup and
// RGB565 pixel serialisation. Every byte is two clocks: WRX low with data
// driven, then WRX high with data held (the panel latches on the rise).
module lcd_8080_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned RST_LOW_CYCLES  = 16000,
    parameter int unsigned RST_WAIT_CYCLES = 1920000,
    parameter logic [7:0]  MADCTL          = 8'h48,
    parameter int unsigned COL_END         = 239,
    parameter int unsigned PAGE_END        = 319
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pix_clk,
    input  logic [15:0] pix_data,
    input  logic        reset_cursor,
    output logic        busy,
    output logic        nreset,
    output logic        cmd_data,
    output logic        write_edge,
    output logic [7:0]  dout
);

    localparam logic [DLY_W-1:0] LOW_LD  = DLY_W'(RST_LOW_CYCLES);
    localparam logic [DLY_W-1:0] WAIT_LD = DLY_W'(RST_WAIT_CYCLES);
    localparam logic [DLY_W-1:0] CNT_ONE = DLY_W'(1);

    lcd_state_t           r_state;
    logic [DLY_W-1:0]     r_cnt;
    logic [ROM_IDX_W-1:0] r_idx;
    logic                 r_dly;
    logic                 r_lo_sent;
    logic [7:0]           r_pix_lo;
    logic                 r_busy;
    logic                 r_nreset;
    logic                 r_dc;
    logic                 r_wr;
    logic [7:0]           r_dout;

    logic [ROM_IDX_W-1:0] w_rom_idx;
    rom_entry_t           w_entry;

    // Index of the next ROM byte to launch: 0 leaving RST_WAIT, window start
    // from IDLE or after the last init byte, otherwise the following entry
    always_comb begin
        w_rom_idx = r_idx + 1'b1;
        if (r_state == ST_RST_WAIT)
            w_rom_idx = '0;
        else if (r_state == ST_IDLE || r_idx == ROM_INIT_LAST)
            w_rom_idx = ROM_WIN_START;
    end

    lcd_init_rom #(
        .MADCTL   (MADCTL),
        .COL_END  (COL_END),
        .PAGE_END (PAGE_END)
    ) u_rom (
        .i_idx   (w_rom_idx),
        .o_entry (w_entry)
    );

    // Main sequencer; all panel pins and busy are registered here
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RST_LOW;
            r_cnt     <= LOW_LD;
            r_idx     <= '0;
            r_dly     <= 1'b0;
            r_lo_sent <= 1'b0;
            r_pix_lo  <= '0;
            r_busy    <= 1'b1;
            r_nreset  <= 1'b0;
            r_dc      <= 1'b1;
            r_wr      <= 1'b1;
            r_dout    <= '0;
        end else begin
            case (r_state)
                ST_RST_LOW: begin
                    if (r_cnt == CNT_ONE) begin
                        r_nreset <= 1'b1;
                        r_cnt    <= WAIT_LD;
                        r_state  <= ST_RST_WAIT;
                    end else
                        r_cnt <= r_cnt - 1'b1;
                end
                ST_RST_WAIT, ST_INIT_DLY: begin
                    if (r_cnt == CNT_ONE) begin
                        r_idx   <= w_rom_idx;
                        r_dout  <= w_entry.data;
                        r_dc    <= w_entry.dc;
                        r_dly   <= w_entry.dly;
                        r_wr    <= 1'b0;
                        r_state <= ST_INIT;
                    end else
                        r_cnt <= r_cnt - 1'b1;
                end
                ST_INIT, ST_WIN: begin
                    if (!r_wr)
                        r_wr <= 1'b1;
                    else if (r_dly) begin
                        // SLPOUT needs the long settle before the next command
                        r_dly   <= 1'b0;
                        r_cnt   <= WAIT_LD;
                        r_state <= ST_INIT_DLY;
                    end else if (r_idx == ROM_WIN_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx   <= w_rom_idx;
                        r_dout  <= w_entry.data;
                        r_dc    <= w_entry.dc;
                        r_dly   <= w_entry.dly;
                        r_wr    <= 1'b0;
                        if (r_idx == ROM_INIT_LAST)
                            r_state <= ST_WIN;
                    end
                end
                ST_IDLE: begin
                    // Cursor reset has priority; a coincident pixel is dropped
                    if (reset_cursor) begin
                        r_idx   <= w_rom_idx;
                        r_dout  <= w_entry.data;
                        r_dc    <= w_entry.dc;
                        r_dly   <= w_entry.dly;
                        r_wr    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_WIN;
                    end else if (pix_clk) begin
                        r_pix_lo  <= pix_data[7:0];
                        r_dout    <= pix_data[15:8];
                        r_dc      <= 1'b1;
                        r_wr      <= 1'b0;
                        r_lo_sent <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_PIX;
                    end
                end
                ST_PIX: begin
                    if (!r_wr)
                        r_wr <= 1'b1;
                    else if (!r_lo_sent) begin
                        r_dout    <= r_pix_lo;
                        r_wr      <= 1'b0;
                        r_lo_sent <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_RST_LOW;
            endcase
        end
    end

    assign busy       = r_busy;
    assign nreset     = r_nreset;
    assign cmd_data   = r_dc;
    assign write_edge = r_wr;
    assign dout       = r_dout;

endmodule

// File: tb/tb_lcd_8080_ctrl.sv
// Bench for lcd_8080_ctrl: stimulus pushes expected panel bytes into a
// queue; a byte monitor pops and compares on every WRX rising edge.
module tb_lcd_8080_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        pix_clk = 1'b0;
    logic [15:0] pix_data = '0;
    logic        reset_cursor = 1'b0;
    logic        busy, nreset, cmd_data, write_edge;
    logic [7:0]  dout;

    int n_pass = 0;
    int n_chk  = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic       prev_we = 1'b1;
    logic       rst_q   = 1'b1;

    lcd_8080_ctrl #(
        .RST_LOW_CYCLES  (4),
        .RST_WAIT_CYCLES (8),
        .MADCTL          (8'h48),
        .COL_END         (239),
        .PAGE_END        (319)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pix_clk      (pix_clk),
        .pix_data     (pix_data),
        .reset_cursor (reset_cursor),
        .busy         (busy),
        .nreset       (nreset),
        .cmd_data     (cmd_data),
        .write_edge   (write_edge),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    // rst_i as seen by the DUT at the last edge; WRX rises forced by reset are not bytes
    always @(posedge clk) rst_q <= rst_i;

    // Panel byte monitor: capture {D/CX, D} on each WRX rise
    always @(negedge clk) begin
        if (!rst_q && write_edge === 1'b1 && prev_we === 1'b0) begin
            n_chk++;
            if (exp_q.size() == 0)
                $display("FAIL byte: got dc=%0b d=%02h, want no byte", cmd_data, dout);
            else begin
                mon_e = exp_q.pop_front();
                if ({cmd_data, dout} === mon_e)
                    n_pass++;
                else
                    $display("FAIL byte: got dc=%0b d=%02h, want dc=%0b d=%02h",
                             cmd_data, dout, mon_e[8], mon_e[7:0]);
            end
        end
        prev_we = write_edge;
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic push(input logic dc, input logic [7:0] b);
        exp_q.push_back({dc, b});
    endtask

    task automatic push_init();
        push(1'b0, 8'h11); push(1'b0, 8'h3A); push(1'b1, 8'h55);
        push(1'b0, 8'h36); push(1'b1, 8'h48); push(1'b0, 8'h29);
    endtask

    task automatic push_win();
        push(1'b0, 8'h2A); push(1'b1, 8'h00); push(1'b1, 8'h00);
        push(1'b1, 8'h00); push(1'b1, 8'hEF);
        push(1'b0, 8'h2B); push(1'b1, 8'h00); push(1'b1, 8'h00);
        push(1'b1, 8'h01); push(1'b1, 8'h3F);
        push(1'b0, 8'h2C);
    endtask

    // Count cycles busy stays high after a strobe; strobes are one cycle wide
    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            pix_clk = 1'b0;
            reset_cursor = 1'b0;
            if (busy !== 1'b1) break;
            n++;
        end
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk("idle timeout", 0, 1);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        chk("bytes outstanding", exp_q.size(), 0);
    endtask

    // Drop rst_i (held for at least one edge) and follow the boot to IDLE
    task automatic boot();
        int low, t;
        push_init();
        push_win();
        low = (nreset === 1'b0) ? 1 : 0;
        t = 0;
        rst_i = 1'b0;
        while (busy !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
            if (nreset === 1'b0) low++;
        end
        chk("nreset low clocks", low, 4);
        // 4 + 2*8 + 2*(7+11) = 56, allowed +-2
        chk("first idle in 54..58", (t >= 54 && t <= 58) ? 1 : 0, 1);
        drain();
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset nreset", int'(nreset), 0);
        chk("reset write_edge", int'(write_edge), 1);
        chk("reset cmd_data", int'(cmd_data), 1);
        chk("reset dout", int'(dout), 0);
        chk("reset busy", int'(busy), 1);

        boot();

        // Pixel: E7 then 61, busy T+1..T+4, low at T+5
        pix_data = 16'hE761; pix_clk = 1'b1;
        push(1'b1, 8'hE7); push(1'b1, 8'h61);
        measure_busy(n);
        chk("pixel busy clocks", n, 4);
        chk("pixel busy at T+5", int'(busy), 0);
        drain();

        // Window re-arm: 11 bytes, 22 busy clocks
        reset_cursor = 1'b1;
        push_win();
        measure_busy(n);
        chk("window busy clocks", n, 22);
        drain();

        // Back-pressure: strobe at T+2 must be ignored
        pix_data = 16'h1234; pix_clk = 1'b1;
        push(1'b1, 8'h12); push(1'b1, 8'h34);
        @(negedge clk); pix_clk = 1'b0;
        @(negedge clk); pix_clk = 1'b1; pix_data = 16'hABCD;
        @(negedge clk); pix_clk = 1'b0;
        wait_idle(20);
        repeat (6) @(negedge clk);
        drain();

        // Collision: cursor reset wins, pixel dropped
        pix_data = 16'h5555; pix_clk = 1'b1; reset_cursor = 1'b1;
        push_win();
        measure_busy(n);
        chk("collision busy clocks", n, 22);
        repeat (6) @(negedge clk);
        drain();

        // Reset during the second byte of a pixel
        pix_data = 16'hE761; pix_clk = 1'b1;
        push(1'b1, 8'hE7);
        @(negedge clk); pix_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("second byte phase A", int'(write_edge), 0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst write_edge", int'(write_edge), 1);
        chk("midrst nreset", int'(nreset), 0);
        chk("midrst busy", int'(busy), 1);
        @(negedge clk);
        boot();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
